rx_flex_stp_deser: RTL and testbench

Receive-side byte deserializer for the USB full-speed datapath; the counterpart of the transmit parallel-to-serial shifter. Takes the synchronized raw line bit on each bit-sample strobe, NRZI-decodes it, removes stuffed bits, and assembles bytes LSB-first. Each completed byte is presented with a one-cycle `byte_ready` pulse to the RX controller and FIFO.

---
 rtl/usb_rx_pkg.sv | 13 +
 rtl/rx_flex_stp_sr.sv | 42 ++++
 rtl/rx_flex_stp_deser.sv | 124 ++++++++++++
 tb/tb_rx_flex_stp_deser.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared constants for the USB full-speed receive datapath
// Contents:
//   USB_STUFF_LEN : decoded ones after which the next bit is a stuff bit
//   USB_BYTE_BITS : bits per assembled byte
//   LINE_J/LINE_K : raw D+ levels for the J (idle) and K states
package usb_rx_pkg;

  localparam int   USB_STUFF_LEN = 6;
  localparam int   USB_BYTE_BITS = 8;
  localparam logic LINE_J        = 1'b1;
  localparam logic LINE_K        = 1'b0;

endpackage

// File: rtl/rx_flex_stp_sr.sv
// rtl/rx_flex_stp_sr.sv - serial-to-parallel shift register, LSB-first
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   shift_enable  : shift one bit in this cycle
//   serial_in     : bit entering at the MSB end
//   clear         : reload the idle pattern (all ones)
//   parallel_out  : current register contents
module rx_flex_stp_sr #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                clear,
  output logic [NUM_BITS-1:0] parallel_out
);

  logic [NUM_BITS-1:0] sr_q;
  logic [NUM_BITS-1:0] sr_d;

  // Right shift: the first bit received ends up at bit 0 after NUM_BITS shifts.
  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '1;
    end else if (shift_enable) begin
      sr_d = {serial_in, sr_q[NUM_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '1;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign parallel_out = sr_q;

endmodule

// File: rtl/rx_flex_stp_deser.sv
// rtl/rx_flex_stp_deser.sv - USB FS receive NRZI decode, bit unstuff and byte assembly
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   shift_strobe  : one-cycle bit-sample pulse
//   d_orig        : synchronized raw D+ level (1 = J)
//   rcv_active    : packet reception in progress
//   rx_byte       : last completed word (registered)
//   byte_ready    : one-cycle pulse when rx_byte updates
//   stuff_err     : one-cycle pulse on a stuff violation
// Build option: RX_STUFF_ERR_EN enables stuff_err and partial-word discard
// on a decoded 1 in a stuff slot; otherwise stuff slots are dropped silently.
module rx_flex_stp_deser
  import usb_rx_pkg::*;
#(
  parameter int NUM_BITS  = USB_BYTE_BITS,
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_strobe,
  input  logic                d_orig,
  input  logic                rcv_active,
  output logic [NUM_BITS-1:0] rx_byte,
  output logic                byte_ready,
  output logic                stuff_err
);

  localparam int BCW = $clog2(NUM_BITS + 1);
  localparam int OCW = $clog2(STUFF_LEN + 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(NUM_BITS - 1);
  localparam logic [OCW-1:0] STUFF_SLOT = OCW'(STUFF_LEN);

  logic                prev_line_q, prev_line_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [OCW-1:0]      ones_cnt_q, ones_cnt_d;
  logic [NUM_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                byte_ready_q, byte_ready_d;
  logic                stuff_err_q, stuff_err_d;
  logic                decoded;
  logic                sr_shift;
  logic                sr_clear;
  logic [NUM_BITS-1:0] sr_word;

  // NRZI: no transition means a 1.
  assign decoded = (d_orig == prev_line_q);

  always_comb begin
    prev_line_d  = prev_line_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    rx_byte_d    = rx_byte_q;
    byte_ready_d = 1'b0;
    stuff_err_d  = 1'b0;
    sr_shift     = 1'b0;
    sr_clear     = 1'b0;

    // Line history follows every strobe, even outside a packet.
    if (shift_strobe) begin
      prev_line_d = d_orig;
    end

    if (!rcv_active) begin
      // Clear wins over a coincident strobe; partial word is dropped.
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
    end else if (shift_strobe) begin
      if (ones_cnt_q == STUFF_SLOT) begin
        ones_cnt_d = '0;
`ifdef RX_STUFF_ERR_EN
        if (decoded) begin
          stuff_err_d = 1'b1;
          bit_cnt_d   = '0;
          sr_clear    = 1'b1;
        end
`endif
      end else begin
        sr_shift   = 1'b1;
        ones_cnt_d = decoded ? ones_cnt_q + 1'b1 : '0;
        if (bit_cnt_q == LAST_BIT) begin
          // Capture the word as it will look after this shift.
          rx_byte_d    = {decoded, sr_word[NUM_BITS-1:1]};
          byte_ready_d = 1'b1;
          bit_cnt_d    = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_line_q  <= LINE_J;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      rx_byte_q    <= '0;
      byte_ready_q <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      prev_line_q  <= prev_line_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      rx_byte_q    <= rx_byte_d;
      byte_ready_q <= byte_ready_d;
      stuff_err_q  <= stuff_err_d;
    end
  end

  rx_flex_stp_sr #(
    .NUM_BITS(NUM_BITS)
  ) u_sr (
    .clk         (clk),
    .rst         (rst),
    .shift_enable(sr_shift),
    .serial_in   (decoded),
    .clear       (sr_clear),
    .parallel_out(sr_word)
  );

  assign rx_byte    = rx_byte_q;
  assign byte_ready = byte_ready_q;
  assign stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_rx_flex_stp_deser.sv
// tb/tb_rx_flex_stp_deser.sv - directed self-checking bench for rx_flex_stp_deser
module tb_rx_flex_stp_deser;

  logic       clk;
  logic       rst;
  logic       shift_strobe;
  logic       d_orig;
  logic       rcv_active;
  logic [7:0] rx_byte;
  logic       byte_ready;
  logic       stuff_err;

  int total;
  int bad;
  int rdy_cnt;
  int err_cnt;
  int rdy_base;
  int err_base;
  logic prev_m;

  rx_flex_stp_deser dut (
    .clk         (clk),
    .rst         (rst),
    .shift_strobe(shift_strobe),
    .d_orig      (d_orig),
    .rcv_active  (rcv_active),
    .rx_byte     (rx_byte),
    .byte_ready  (byte_ready),
    .stuff_err   (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally pulses seen there.
  task automatic cyc();
    @(negedge clk);
    rdy_cnt += int'(byte_ready);
    err_cnt += int'(stuff_err);
  endtask

  task automatic idle(input int n);
    shift_strobe = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Drive one strobe whose NRZI-decoded value is dec.
  task automatic send(input logic dec);
    d_orig       = dec ? prev_m : ~prev_m;
    prev_m       = d_orig;
    shift_strobe = 1'b1;
    cyc();
    shift_strobe = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) send(bits[i]);
  endtask

  task automatic restart();
    rcv_active = 1'b0;
    idle(1);
    rcv_active = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; rdy_cnt = 0; err_cnt = 0;
    rst = 1'b1; shift_strobe = 1'b0; d_orig = 1'b1; rcv_active = 1'b0;
    prev_m = 1'b1;
    idle(2);
    chk("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
    chk("reset_byte_ready", {31'd0, byte_ready}, 32'h0);
    chk("reset_stuff_err", {31'd0, stuff_err}, 32'h0);
    rst = 1'b0;
    idle(1);

    // Reset mid-word, then inactive strobes.
    rcv_active = 1'b1;
    send_bits(16'h0005, 4);
    rst = 1'b1;
    idle(1);
    prev_m = 1'b1;
    rst = 1'b0;
    rcv_active = 1'b0;
    rdy_base = rdy_cnt; err_base = err_cnt;
    for (int i = 0; i < 20; i++) send((i % 3) == 0);
    idle(1);
    chk("inactive_ready_pulses", rdy_cnt - rdy_base, 0);
    chk("inactive_err_pulses", err_cnt - err_base, 0);
    chk("inactive_rx_byte", {24'd0, rx_byte}, 32'h00);

    // Eight line toggles: decoded zeros.
    rcv_active = 1'b1;
    send_bits(16'h0000, 7);
    chk("zeros_no_early_ready", {31'd0, byte_ready}, 32'h0);
    send(1'b0);
    chk("zeros_ready", {31'd0, byte_ready}, 32'h1);
    chk("zeros_rx_byte", {24'd0, rx_byte}, 32'h00);
    idle(1);
    chk("zeros_ready_one_cycle", {31'd0, byte_ready}, 32'h0);

    // 1,0,1,0,0,1,0,1 LSB-first -> A5.
    restart();
    rdy_base = rdy_cnt;
    send_bits(16'h00A5, 8);
    chk("a5_ready", {31'd0, byte_ready}, 32'h1);
    chk("a5_rx_byte", {24'd0, rx_byte}, 32'hA5);
    idle(2);
    chk("a5_single_pulse", rdy_cnt - rdy_base, 1);
    chk("a5_rx_byte_holds", {24'd0, rx_byte}, 32'hA5);

    // Six ones, stuffed zero, two ones -> FF after nine strobes.
    restart();
    send_bits(16'h003F, 6);
    send(1'b0);
    send(1'b1);
    chk("stuff_not_counted", {31'd0, byte_ready}, 32'h0);
    send(1'b1);
    chk("stuff_ready", {31'd0, byte_ready}, 32'h1);
    chk("stuff_rx_byte", {24'd0, rx_byte}, 32'hFF);

    // Seven ones: the seventh lands in a stuff slot.
    restart();
    rdy_base = rdy_cnt;
    send_bits(16'h007F, 7);
`ifdef RX_STUFF_ERR_EN
    chk("violation_stuff_err", {31'd0, stuff_err}, 32'h1);
`else
    chk("violation_stuff_err", {31'd0, stuff_err}, 32'h0);
`endif
    chk("violation_no_ready", {31'd0, byte_ready}, 32'h0);
`ifdef RX_STUFF_ERR_EN
    send_bits(16'h0000, 7);
    chk("after_err_no_early_ready", {31'd0, byte_ready}, 32'h0);
    send(1'b0);
    chk("after_err_ready", {31'd0, byte_ready}, 32'h1);
    chk("after_err_rx_byte", {24'd0, rx_byte}, 32'h00);
`else
    // Six ones kept, two zeros complete the word: 0011_1111.
    send(1'b0);
    chk("silent_no_early_ready", {31'd0, byte_ready}, 32'h0);
    send(1'b0);
    chk("silent_ready", {31'd0, byte_ready}, 32'h1);
    chk("silent_rx_byte", {24'd0, rx_byte}, 32'h3F);
    send_bits(16'h0000, 6);
`endif
    idle(1);
    chk("violation_ready_pulses", rdy_cnt - rdy_base, 1);

    // Partial word dropped; the drop cycle carries a strobe that must not count.
    restart();
    rdy_base = rdy_cnt;
    send_bits(16'h000B, 5);
    rcv_active = 1'b0;
    send(1'b0);
    rcv_active = 1'b1;
    send(1'b0);
    send_bits(16'h003F, 6);
    send(1'b0);
    chk("partial_no_early_ready", {31'd0, byte_ready}, 32'h0);
    send(1'b1);
    chk("partial_ready", {31'd0, byte_ready}, 32'h1);
    chk("partial_rx_byte", {24'd0, rx_byte}, 32'hFE);
    idle(2);
    chk("partial_single_pulse", rdy_cnt - rdy_base, 1);
    chk("no_stray_err", {31'd0, stuff_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
